// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback source handshakes and the two PRF write ports
//   master: execution units / PRF side (drives valid, rd, data; sees ready and write ports)
//   slave : the arbiter (sees valid, rd, data; drives ready and write ports)
interface wb_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PHY_WIDTH  = 6
);
    logic                  alu_wb_valid, ls_wb_valid, branch_wb_valid;
    logic                  alu_wb_ready, ls_wb_ready, branch_wb_ready;
    logic [PHY_WIDTH-1:0]  alu_wb_rd, ls_wb_rd, branch_wb_rd;
    logic [DATA_WIDTH-1:0] alu_wb_data, ls_wb_data, branch_wb_data;
    logic                  wb0_en, wb1_en;
    logic [PHY_WIDTH-1:0]  wb0_rd, wb1_rd;
    logic [DATA_WIDTH-1:0] wb0_data, wb1_data;

    modport master (
        output alu_wb_valid, ls_wb_valid, branch_wb_valid,
        output alu_wb_rd, ls_wb_rd, branch_wb_rd,
        output alu_wb_data, ls_wb_data, branch_wb_data,
        input  alu_wb_ready, ls_wb_ready, branch_wb_ready,
        input  wb0_en, wb1_en, wb0_rd, wb1_rd, wb0_data, wb1_data
    );

    modport slave (
        input  alu_wb_valid, ls_wb_valid, branch_wb_valid,
        input  alu_wb_rd, ls_wb_rd, branch_wb_rd,
        input  alu_wb_data, ls_wb_data, branch_wb_data,
        output alu_wb_ready, ls_wb_ready, branch_wb_ready,
        output wb0_en, wb1_en, wb0_rd, wb1_rd, wb0_data, wb1_data
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin sharing of two registered PRF write ports among alu(0), ls(1), branch(2)
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : synchronous flush; blocks grants, clears write enables and rr_ptr
//   bus            : source valid/ready/rd/data and wb0/wb1 write ports (slave modport)
//   rr_ptr         : highest-priority source for the current cycle
//   conflict_err   : sticky, both grants of one cycle targeted the same rd
module wb_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int PHY_WIDTH  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    wb_port_arbiter_if.slave    bus,
    output logic [1:0]          rr_ptr,
    output logic                conflict_err
);
    function automatic logic [1:0] f_next(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction

    logic [1:0]            r_ptr;
    logic                  r_conflict;
    logic                  r_wb0_en, r_wb1_en;
    logic [PHY_WIDTH-1:0]  r_wb0_rd, r_wb1_rd;
    logic [DATA_WIDTH-1:0] r_wb0_data, r_wb1_data;

    logic [1:0]            w_ptr, w_s0, w_s1, w_s2, w_src0, w_src1, w_last;
    logic [2:0]            w_v, w_rv, w_gnt;
    logic                  w_act, w_g0, w_g1;
    logic [PHY_WIDTH-1:0]  w_rd [3];
    logic [DATA_WIDTH-1:0] w_data [3];

    assign w_v    = {bus.branch_wb_valid, bus.ls_wb_valid, bus.alu_wb_valid};
    assign w_rd   = '{bus.alu_wb_rd, bus.ls_wb_rd, bus.branch_wb_rd};
    assign w_data = '{bus.alu_wb_data, bus.ls_wb_data, bus.branch_wb_data};
    assign w_act  = rst_n & ~flush;
    // an illegal pointer value of 3 behaves as 0
    assign w_ptr  = r_ptr == 2'd3 ? 2'd0 : r_ptr;
    assign w_s0   = w_ptr;
    assign w_s1   = f_next(w_s0);
    assign w_s2   = f_next(w_s1);
    // valids rotated into scan order: bit k is the source k steps after the pointer
    assign w_rv   = {w_v[w_s2], w_v[w_s1], w_v[w_s0]};
    assign w_g0   = w_act & (|w_rv);
    assign w_g1   = w_act & ((w_rv[0] & w_rv[1]) | (w_rv[2] & (w_rv[0] | w_rv[1])));
    assign w_src0 = w_rv[0] ? w_s0 : w_rv[1] ? w_s1 : w_s2;
    // with two grants the second is s1 only when s0 and s1 are both valid, otherwise s2
    assign w_src1 = (w_rv[0] & w_rv[1]) ? w_s1 : w_s2;
    assign w_last = w_g1 ? w_src1 : w_src0;
    assign w_gnt  = ({3{w_g0}} & (3'b001 << w_src0)) | ({3{w_g1}} & (3'b001 << w_src1));

    assign bus.alu_wb_ready    = w_gnt[0];
    assign bus.ls_wb_ready     = w_gnt[1];
    assign bus.branch_wb_ready = w_gnt[2];
    assign bus.wb0_en          = r_wb0_en;
    assign bus.wb1_en          = r_wb1_en;
    assign bus.wb0_rd          = r_wb0_rd;
    assign bus.wb1_rd          = r_wb1_rd;
    assign bus.wb0_data        = r_wb0_data;
    assign bus.wb1_data        = r_wb1_data;
    assign rr_ptr              = r_ptr;
    assign conflict_err        = r_conflict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 2'd0;
            r_conflict <= 1'b0;
            r_wb0_en   <= 1'b0;
            r_wb1_en   <= 1'b0;
            r_wb0_rd   <= '0;
            r_wb1_rd   <= '0;
            r_wb0_data <= '0;
            r_wb1_data <= '0;
        end else if (flush) begin
            r_ptr    <= 2'd0;
            r_wb0_en <= 1'b0;
            r_wb1_en <= 1'b0;
        end else begin
            r_wb0_en <= w_g0;
            r_wb1_en <= w_g1;
            r_ptr    <= w_g0 ? f_next(w_last) : w_ptr;
            if (w_g0) begin
                r_wb0_rd   <= w_rd[w_src0];
                r_wb0_data <= w_data[w_src0];
            end
            if (w_g1) begin
                r_wb1_rd   <= w_rd[w_src1];
                r_wb1_data <= w_data[w_src1];
            end
            if (w_g1 && w_rd[w_src0] == w_rd[w_src1])
                r_conflict <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] rr_ptr;
    logic       conflict_err;
    int         checks = 0;
    int         failures = 0;

    wb_port_arbiter_if #(.DATA_WIDTH(32), .PHY_WIDTH(6)) bus ();

    wb_port_arbiter #(.DATA_WIDTH(32), .PHY_WIDTH(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .rr_ptr       (rr_ptr),
        .conflict_err (conflict_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic src(input int i, input logic v, input logic [5:0] rd, input logic [31:0] d);
        if (i == 0) begin
            bus.alu_wb_valid = v; bus.alu_wb_rd = rd; bus.alu_wb_data = d;
        end else if (i == 1) begin
            bus.ls_wb_valid = v; bus.ls_wb_rd = rd; bus.ls_wb_data = d;
        end else begin
            bus.branch_wb_valid = v; bus.branch_wb_rd = rd; bus.branch_wb_data = d;
        end
    endtask

    // ready vector ordered {alu, ls, branch}
    task automatic chk_rdy(input string tag, input logic [2:0] exp);
        #1;
        chk(tag, {61'd0, bus.alu_wb_ready, bus.ls_wb_ready, bus.branch_wb_ready}, {61'd0, exp});
    endtask

    task automatic chk_wb(input string tag, input logic e0, input logic [5:0] rd0, input logic [31:0] d0,
                          input logic e1, input logic [5:0] rd1, input logic [31:0] d1, input logic [1:0] ptr);
        chk({tag, "_en"}, {61'd0, bus.wb0_en, bus.wb1_en, 1'b0}, {61'd0, e0, e1, 1'b0});
        chk({tag, "_ptr"}, {62'd0, rr_ptr}, {62'd0, ptr});
        if (e0) chk({tag, "_p0"}, {26'd0, bus.wb0_rd, bus.wb0_data}, {26'd0, rd0, d0});
        if (e1) chk({tag, "_p1"}, {26'd0, bus.wb1_rd, bus.wb1_data}, {26'd0, rd1, d1});
    endtask

    initial begin
        src(0, 1'b0, 6'd0, 32'd0);
        src(1, 1'b0, 6'd0, 32'd0);
        src(2, 1'b0, 6'd0, 32'd0);
        repeat (2) tick();
        chk("rst_hold", {bus.wb0_en, bus.wb1_en, rr_ptr, conflict_err, bus.wb0_rd, bus.wb1_rd, bus.wb0_data[18:0]}, 64'd0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_ctl", {57'd0, bus.wb0_en, bus.wb1_en, rr_ptr, conflict_err,
                             bus.alu_wb_ready, bus.ls_wb_ready}, {64'd0});
            chk("idle_dat", {bus.wb0_data, bus.wb1_data}, 64'd0);
        end

        src(0, 1'b1, 6'd5, 32'hDEADBEEF);
        chk_rdy("single_rdy", 3'b100);
        tick();
        chk_wb("single", 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'd0, 2'd1);
        src(0, 1'b0, 6'd0, 32'd0);
        src(2, 1'b1, 6'd7, 32'h77);
        chk_rdy("br_only_rdy", 3'b001);
        tick();
        chk_wb("br_only", 1'b1, 6'd7, 32'h77, 1'b0, 6'd0, 32'd0, 2'd0);

        src(0, 1'b1, 6'd1, 32'hA1);
        src(1, 1'b1, 6'd2, 32'hB2);
        src(2, 1'b1, 6'd3, 32'hC3);
        chk_rdy("rr1_rdy", 3'b110);
        tick();
        chk_wb("rr1", 1'b1, 6'd1, 32'hA1, 1'b1, 6'd2, 32'hB2, 2'd2);
        src(0, 1'b1, 6'd4, 32'hA4);
        src(1, 1'b1, 6'd5, 32'hB5);
        chk_rdy("rr2_rdy", 3'b101);
        tick();
        chk_wb("rr2", 1'b1, 6'd3, 32'hC3, 1'b1, 6'd4, 32'hA4, 2'd1);
        src(0, 1'b1, 6'd6, 32'hA6);
        src(2, 1'b1, 6'd8, 32'hC8);
        chk_rdy("rr3_rdy", 3'b011);
        tick();
        chk_wb("rr3", 1'b1, 6'd5, 32'hB5, 1'b1, 6'd8, 32'hC8, 2'd0);

        src(1, 1'b0, 6'd0, 32'd0);
        src(2, 1'b0, 6'd0, 32'd0);
        chk_rdy("pre_fl_rdy", 3'b100);
        tick();
        chk_wb("pre_fl", 1'b1, 6'd6, 32'hA6, 1'b0, 6'd0, 32'd0, 2'd1);
        src(0, 1'b1, 6'd11, 32'hA11);
        src(1, 1'b1, 6'd9, 32'hB9);
        src(2, 1'b1, 6'd10, 32'hC10);
        flush = 1'b1;
        chk_rdy("flush_rdy", 3'b000);
        chk_wb("flush_n", 1'b1, 6'd6, 32'hA6, 1'b0, 6'd0, 32'd0, 2'd1);
        tick();
        chk_wb("flush_n1", 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 2'd0);
        flush = 1'b0;

        src(0, 1'b1, 6'd12, 32'h1);
        src(1, 1'b1, 6'd12, 32'h2);
        src(2, 1'b0, 6'd0, 32'd0);
        chk("conf_pre", {63'd0, conflict_err}, 64'd0);
        chk_rdy("conf_rdy", 3'b110);
        tick();
        chk_wb("conf", 1'b1, 6'd12, 32'h1, 1'b1, 6'd12, 32'h2, 2'd2);
        chk("conf_set", {63'd0, conflict_err}, 64'd1);
        src(0, 1'b0, 6'd0, 32'd0);
        src(1, 1'b0, 6'd0, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("conf_sticky", {63'd0, conflict_err}, 64'd1);

        src(0, 1'b1, 6'd20, 32'h20);
        src(1, 1'b1, 6'd21, 32'h21);
        src(2, 1'b1, 6'd22, 32'h22);
        tick();
        chk_wb("stream", 1'b1, 6'd20, 32'h20, 1'b1, 6'd21, 32'h21, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {bus.wb0_en, bus.wb1_en, rr_ptr, conflict_err, bus.alu_wb_ready, bus.ls_wb_ready,
                          bus.branch_wb_ready, bus.wb0_rd, bus.wb1_rd, bus.wb1_data[23:0], bus.wb0_data[19:0]}, 64'd0);
        #2 rst_n = 1'b1;
        chk_rdy("post_rst_rdy", 3'b110);
        tick();
        chk_wb("post_rst", 1'b1, 6'd20, 32'h20, 1'b1, 6'd21, 32'h21, 2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the two physical-register-file write ports between three writeback sources: ALU, load/store and branch. Each source uses a valid/ready handshake. Up to two requests are granted per cycle in round-robin order, and the granted results are driven onto registered write ports one cycle later. The block sits between the execution units and the PRF writeback interface and replaces the direct per-unit write enables.

## Interface
- DATA_WIDTH, 32, result data width
- PHY_WIDTH, 6, physical register index width
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush
- alu_wb_valid / ls_wb_valid / branch_wb_valid  in  1 each  source holds a result
- alu_wb_ready / ls_wb_ready / branch_wb_ready  out  1 each  combinational grant; transfer occurs when valid && ready
- alu_wb_rd / ls_wb_rd / branch_wb_rd  in  PHY_WIDTH each  destination physical register
- alu_wb_data / ls_wb_data / branch_wb_data  in  DATA_WIDTH each  result value
- wb0_en, wb1_en  out  1 each  registered PRF write enables
- wb0_rd, wb1_rd  out  PHY_WIDTH each  registered write addresses
- wb0_data, wb1_data  out  DATA_WIDTH each  registered write data
- rr_ptr  out  2  current highest-priority source: 0=alu, 1=ls, 2=branch
- conflict_err  out  1  sticky flag: two grants targeted the same rd in one cycle

## Operation
- Source indices are fixed: alu=0, ls=1, branch=2.
- Scan order is cyclic from rr_ptr: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- Grants: the first two valid sources in scan order get ready=1. The third valid source gets ready=0 and must hold valid, rd and data stable until it is granted.
- ready is a function of all valids, rr_ptr and flush. It may depend on the source's own valid. ready=0 whenever that source's valid=0.
- Port mapping: the first grant in scan order goes to port 0, the second to port 1. A single grant always uses port 0, and wb1_en=0.
- rr_ptr update, at posedge after a non-flush cycle:
  - at least one grant: rr_ptr = (index of the last granted source + 1) mod 3;
  - no grant: unchanged.
- rr_ptr never takes the value 3. If it is forced to 3, treat it as 0 and load 0 at the next edge.
- Starvation bound: a continuously valid source is granted within 2 cycles.
- conflict_err: set when both grants in one cycle carry an equal rd. It stays set until reset; flush does not clear it. Both writes are still issued, and port 1 wins at the PRF.
- Flush, in the cycle flush=1:
  - all ready outputs are 0 and nothing is consumed;
  - at the next edge wb0_en=wb1_en=0 and rr_ptr=0.
  - Sources drop their valids themselves.
- Reset (rst_n=0, asynchronous): wb0_en=wb1_en=0; wb0_rd=wb1_rd=0; wb0_data=wb1_data=0; rr_ptr=0; conflict_err=0. Ready outputs are 0 while reset is asserted. Reset asserted mid-transfer discards any pending grant.

## Timing
- Grant to write: 1 cycle. A handshake in cycle N drives wbX_en/rd/data during cycle N+1, from posedge N+1 to posedge N+2.
- The outputs are flops, so they are stable before the PRF's negedge write in cycle N+1.
- The wbX_en outputs are single-cycle pulses per grant. Back-to-back grants produce consecutive pulses with no bubble.
- Throughput: 2 writes per cycle. With three sources continuously valid, each source averages 2 grants per 3 cycles.
- No combinational path from any input to the wb* outputs or rr_ptr. Input-to-ready is combinational.

## Test plan
- Reset/idle: hold rst_n=0, then release with all valids=0 -> all outputs 0, rr_ptr=0, all ready=0 for 5 cycles.
- Single source: alu valid with rd=5, data=0xDEADBEEF at cycle N -> alu_ready=1 at N. At N+1: wb0_en=1, wb0_rd=5, wb0_data=0xDEADBEEF, wb1_en=0. rr_ptr becomes 1.
- Three-way contention, all valid for 3 cycles from rr_ptr=0:
  - cycle 1 grants alu→port0, ls→port1;
  - cycle 2 grants branch→port0, alu→port1;
  - cycle 3 grants ls→port0, branch→port1;
  - rr_ptr sequence 0,2,1,0. The held source keeps its data stable and the data is verified.
- Flush: three valids plus flush=1 at cycle N -> all ready=0 at N, wb0_en=wb1_en=0 at N+1, rr_ptr=0 at N+1. Earlier grant outputs at N complete normally.
- Conflict: alu and ls both valid with rd=12 (data 0x1, 0x2) -> wb0_rd=wb1_rd=12, conflict_err=1 from N+1. conflict_err is still 1 after a flush and clears only on rst_n=0.
- Async reset mid-stream: drop rst_n during continuous traffic between clock edges -> outputs clear immediately without waiting for clk. The first grant after release is issued from rr_ptr=0.
